dmem_responder: RTL and testbench

Word-addressed data-memory responder for the pipelined CPU's MEM stage, serving the CPU's memory-control, address and write-data outputs. Reads return data combinationally in the same cycle. Writes are posted into a small FIFO write buffer that drains into a single-port storage array whenever the port is not needed for a read. Read data is forwarded from the buffer, youngest entry first, so the CPU never sees stale data.

---
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Word-addressed data memory for the MEM stage of the pipelined CPU.
// Loads are answered combinationally in the same cycle. Stores are posted
// into a small circular FIFO write buffer. The buffer drains one entry per
// cycle into a single-port register array, but only in cycles that do not
// need the port for a load. Loads are forwarded from the buffer, youngest
// matching entry first, so the CPU never observes stale data.
//
// Parameters:
//   WIDTH      data word width
//   ADDR_BITS  array index width (2**ADDR_BITS words); upper address bits ignored
//   BUF_DEPTH  write-buffer entries (power of two, >= 2)
//
// Ports:
//   clk_i        single clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset (clears buffer and array)
//   mem_ctrl_i   bit1 = write, bit0 = read
//   addr_i       word address (only the low ADDR_BITS bits are used)
//   wdata_i      store data
//   rdata_o      load data, combinational
//   buf_empty_o  write buffer holds no valid entries
//   buf_count_o  number of valid buffer entries
//   rd_cnt_o     (DMEM_STATS_EN only) read-cycle counter, wraps at 2**16
//   wr_cnt_o     (DMEM_STATS_EN only) write-cycle counter, wraps at 2**16
//   fwd_cnt_o    (DMEM_STATS_EN only) reads served from the buffer, wraps at 2**16
//
// Optional feature macro: DMEM_STATS_EN
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 7,
    parameter int BUF_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [1:0]                   mem_ctrl_i,
    input  logic [WIDTH-1:0]             addr_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         buf_empty_o,
    output logic [$clog2(BUF_DEPTH):0]   buf_count_o
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]                  rd_cnt_o,
    output logic [15:0]                  wr_cnt_o,
    output logic [15:0]                  fwd_cnt_o
`endif
);

    localparam int PW    = $clog2(BUF_DEPTH);
    localparam int CW    = PW + 1;
    localparam int WORDS = 1 << ADDR_BITS;

    // Backing store
    logic [WIDTH-1:0]     mem_q      [WORDS];

    // Write buffer entries and bookkeeping
    logic [ADDR_BITS-1:0] buf_idx_q  [BUF_DEPTH];
    logic [WIDTH-1:0]     buf_data_q [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] buf_vld_q;
    logic [PW-1:0]        head_q;
    logic [PW-1:0]        tail_q;
    logic [CW-1:0]        count_q;

    logic [ADDR_BITS-1:0] index;
    logic                 is_write;
    logic                 is_read;
    logic                 do_drain;
    logic                 fwd_hit;
    logic [WIDTH-1:0]     fwd_data;
    logic [PW-1:0]        scan_pos;

    // Address bits above the array index carry no meaning here.
    logic                 unused_addr_bits;
    assign unused_addr_bits = ^addr_i[WIDTH-1:ADDR_BITS];

    assign index    = addr_i[ADDR_BITS-1:0];
    assign is_write = mem_ctrl_i[1];
    assign is_read  = mem_ctrl_i[0];

    // The array port is free whenever no load is in flight, so the oldest
    // entry retires then. A plain store never carries a load, which is why
    // a full buffer always drains on a store and cannot overflow.
    assign do_drain = !is_read && (count_q != '0);

    assign buf_empty_o = (count_q == '0);
    assign buf_count_o = count_q;

    // Forwarding lookup. Entries are scanned oldest (head) to youngest, so
    // the last match written wins and the youngest duplicate is returned.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_pos = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            scan_pos = head_q + PW'(i);
            if (buf_vld_q[scan_pos] && (buf_idx_q[scan_pos] == index)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data_q[scan_pos];
            end
        end
    end

    assign rdata_o = fwd_hit ? fwd_data : mem_q[index];

    // Buffer state. Drain is handled before enqueue so that, when the buffer
    // is full and head equals tail, the retiring slot is refilled valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_vld_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            if (do_drain) begin
                buf_vld_q[head_q] <= 1'b0;
                head_q            <= head_q + PW'(1);
            end
            if (is_write) begin
                buf_idx_q[tail_q]  <= index;
                buf_data_q[tail_q] <= wdata_i;
                buf_vld_q[tail_q]  <= 1'b1;
                tail_q             <= tail_q + PW'(1);
            end
            case ({is_write, do_drain})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Backing store takes the head entry on a drain cycle. Reset wipes it,
    // so pending buffer contents are discarded rather than written back.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < WORDS; w++) begin
                mem_q[w] <= '0;
            end
        end else if (do_drain) begin
            mem_q[buf_idx_q[head_q]] <= buf_data_q[head_q];
        end
    end

`ifdef DMEM_STATS_EN
    // Activity counters. A 2'b11 cycle is a write only, so it does not count
    // as a read; forwarded reads are the subset of reads hit in the buffer.
    logic rd_cycle;
    assign rd_cycle = (mem_ctrl_i == 2'b01);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_o  <= '0;
            wr_cnt_o  <= '0;
            fwd_cnt_o <= '0;
        end else begin
            if (rd_cycle) begin
                rd_cnt_o <= rd_cnt_o + 16'd1;
            end
            if (is_write) begin
                wr_cnt_o <= wr_cnt_o + 16'd1;
            end
            if (rd_cycle && fwd_hit) begin
                fwd_cnt_o <= fwd_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed self-checking bench for dmem_responder with default parameters
// (WIDTH=32, ADDR_BITS=7, BUF_DEPTH=4). Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [1:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        buf_empty;
    logic [2:0]  buf_count;
`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    logic [15:0] fwd_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    dmem_responder #(
        .WIDTH     (32),
        .ADDR_BITS (7),
        .BUF_DEPTH (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_ctrl_i  (ctrl),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .buf_empty_o (buf_empty),
        .buf_count_o (buf_count)
`ifdef DMEM_STATS_EN
        ,
        .rd_cnt_o    (rd_cnt),
        .wr_cnt_o    (wr_cnt),
        .fwd_cnt_o   (fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The CPU must never issue 2'b11 against a full buffer.
    always @(posedge clk) begin
        if (!rst && ctrl == 2'b11) begin
            assert (buf_count < 3'd4) else begin
                n_err++;
                $error("[TB] FAIL ctrl11_full: observed count %0d, required below 4", buf_count);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
        ctrl  = c;
        addr  = a;
        wdata = d;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        ctrl  = 2'b00;
        addr  = '0;
        wdata = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        drive(2'b01, 32'd5, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_empty", 32'(buf_empty), 32'd1);
        check("rst_count", 32'(buf_count), 32'd0);
        tick();

        // Store then load from buffer, then from array after drain
        drive(2'b10, 32'd3, 32'hDEADBEEF);
        tick();
        drive(2'b01, 32'd3, 32'd0);
        check("fwd_rdata", rdata, 32'hDEADBEEF);
        check("fwd_count", 32'(buf_count), 32'd1);
        tick();
        drive(2'b00, 32'd0, 32'd0);
        check("read_blocks_drain", 32'(buf_count), 32'd1);
        tick();
        drive(2'b01, 32'd3, 32'd0);
        check("drained_empty", 32'(buf_empty), 32'd1);
        check("array_rdata", rdata, 32'hDEADBEEF);
        tick();

        // Back-to-back stores to the same address
        drive(2'b10, 32'd7, 32'h1);
        tick();
        drive(2'b10, 32'd7, 32'h2);
        tick();
        drive(2'b01, 32'd7, 32'd0);
        check("dup_fwd", rdata, 32'h2);
        tick();
        drive(2'b00, 32'd0, 32'd0);
        tick();
        tick();
        drive(2'b01, 32'd7, 32'd0);
        check("dup_array", rdata, 32'h2);
        check("dup_empty_count", 32'(buf_count), 32'd0);
        tick();

        // Five consecutive stores: drain each cycle keeps count at 1
        for (int k = 0; k < 5; k++) begin
            drive(2'b10, 32'(k), 32'h10 + 32'(k));
            tick();
            check($sformatf("stream_count_%0d", k), 32'(buf_count), 32'd1);
        end
        drive(2'b00, 32'd0, 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(2'b01, 32'(k), 32'd0);
            check($sformatf("stream_rd_%0d", k), rdata, 32'h10 + 32'(k));
            tick();
        end

        // Alternating store/load: each store drains the previous entry
        for (int k = 0; k < 4; k++) begin
            drive(2'b10, 32'd20 + 32'(k), 32'h100 + 32'(k));
            tick();
            drive(2'b01, 32'd20 + 32'(k), 32'd0);
            check($sformatf("alt_rd_%0d", k), rdata, 32'h100 + 32'(k));
            check($sformatf("alt_count_%0d", k), 32'(buf_count), 32'd1);
            tick();
        end
        drive(2'b00, 32'd0, 32'd0);
        tick();

        // Fill the buffer with drain-suppressed stores (with a duplicate)
        drive(2'b11, 32'd30, 32'h200);
        tick();
        drive(2'b11, 32'd31, 32'h201);
        tick();
        drive(2'b11, 32'd30, 32'h202);
        tick();
        drive(2'b11, 32'd32, 32'h203);
        tick();
        drive(2'b01, 32'd30, 32'd0);
        check("full_count", 32'(buf_count), 32'd4);
        check("full_youngest", rdata, 32'h202);
        drive(2'b01, 32'd31, 32'd0);
        check("full_rd31", rdata, 32'h201);
        drive(2'b01, 32'd5, 32'd0);
        check("full_nomatch", rdata, 32'h0);
        tick();

        // Plain store at full: head retires, count stays 4
        drive(2'b10, 32'd33, 32'h204);
        tick();
        drive(2'b01, 32'd30, 32'd0);
        check("full_wr_count", 32'(buf_count), 32'd4);
        check("full_wr_rd30", rdata, 32'h202);
        drive(2'b01, 32'd33, 32'd0);
        check("full_wr_rd33", rdata, 32'h204);
        tick();
        drive(2'b00, 32'd0, 32'd0);
        for (int k = 0; k < 4; k++) tick();
        drive(2'b01, 32'd30, 32'd0);
        check("drain4_empty", 32'(buf_empty), 32'd1);
        check("drain4_rd30", rdata, 32'h202);
        drive(2'b01, 32'd32, 32'd0);
        check("drain4_rd32", rdata, 32'h203);
        // Upper address bits ignored: 0x83 maps to index 3
        drive(2'b01, 32'h0000_0083, 32'd0);
        check("alias_rd", rdata, 32'h13);
        tick();

        // Reset with pending entries and a same-cycle store
        drive(2'b11, 32'd40, 32'h300);
        tick();
        drive(2'b11, 32'd41, 32'h301);
        tick();
        drive(2'b11, 32'd42, 32'h302);
        tick();
        drive(2'b00, 32'd0, 32'd0);
        check("pend_count", 32'(buf_count), 32'd3);
        rst = 1'b1;
        drive(2'b10, 32'd43, 32'h303);
        tick();
        rst = 1'b0;
        drive(2'b01, 32'd40, 32'd0);
        check("rst2_count", 32'(buf_count), 32'd0);
        check("rst2_empty", 32'(buf_empty), 32'd1);
        check("rst2_rd40", rdata, 32'h0);
        drive(2'b01, 32'd42, 32'd0);
        check("rst2_rd42", rdata, 32'h0);
        drive(2'b01, 32'd43, 32'd0);
        check("rst2_rd43", rdata, 32'h0);
        drive(2'b01, 32'd3, 32'd0);
        check("rst2_rd3", rdata, 32'h0);
`ifdef DMEM_STATS_EN
        check("rst2_rd_cnt", 32'(rd_cnt), 32'd0);
        check("rst2_wr_cnt", 32'(wr_cnt), 32'd0);
        check("rst2_fwd_cnt", 32'(fwd_cnt), 32'd0);
`endif
        drive(2'b00, 32'd0, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
